// File: rtl/nco_tdm_multichan_if.sv
// Config request port and channel-tagged sin/cos output stream of the
// time-multiplexed NCO. The master drives config and consumes samples.
interface nco_tdm_multichan_if #(
    parameter int CHW = 2,
    parameter int APR = 32,
    parameter int MPR = 18
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [1:0]            cfg_sel;
    logic [CHW-1:0]        cfg_chan;
    logic [APR-1:0]        cfg_data;
    logic signed [MPR-1:0] fsin_o;
    logic signed [MPR-1:0] fcos_o;
    logic [CHW-1:0]        out_chan;
    logic                  out_valid;

    modport master (
        output cfg_valid, cfg_sel, cfg_chan, cfg_data,
        input  cfg_ready, fsin_o, fcos_o, out_chan, out_valid
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_chan, cfg_data,
        output cfg_ready, fsin_o, fcos_o, out_chan, out_valid
    );
endinterface

// File: rtl/nco_tdm_multichan.sv
// Time-multiplexed multi-channel NCO: NC phase accumulators share one
// quarter-wave sin/cos table through a 4-stage clken-qualified pipeline.
// Per-channel increment, offset and accumulator clear are loaded through a
// one-deep pending config slot and applied when the target channel's slot
// comes round. Table contents are computed at elaboration from the
// quarter-sine formula, so no init file is needed.
module nco_tdm_multichan #(
    parameter int NC  = 4,
    parameter int CHW = 2,
    parameter int APR = 32,
    parameter int MPR = 18,
    parameter int LAW = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    nco_tdm_multichan_if.slave bus
);
    localparam int  N   = 1 << LAW;
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = real'((1 << (MPR - 1)) - 1);

    // Quarter-wave table R[k] = round(AMP * sin(pi/2 * k/N)), k = 0..N
    logic [MPR-2:0] rom [0:N];
    for (genvar k = 0; k <= N; k++) begin : g_rom
        localparam int RV = $rtoi(AMP * $sin(PI / 2.0 * real'(k) / real'(N)) + 0.5);
        assign rom[k] = RV[MPR-2:0];
    end

    // Per-channel state
    logic [NC-1:0][APR-1:0] acc_q, acc_d, inc_q, inc_d, off_q, off_d;
    logic [CHW-1:0]         slot_q, slot_d;

    // Pending config slot
    logic                   pend_q, pend_d;
    logic [1:0]             psel_q, psel_d;
    logic [CHW-1:0]         pchan_q, pchan_d;
    logic [APR-1:0]         pdata_q, pdata_d;
    logic                   rdy_q, rdy_d;

    // Pipeline: S1 phase, S2 quadrant/addresses, S3 table reads, S4 outputs
    logic [4:1]             vld_pipe_q, vld_pipe_d;
    logic [LAW+1:0]         ph1_q, ph1_d;
    logic [CHW-1:0]         ch1_q, ch1_d, ch2_q, ch2_d, ch3_q, ch3_d, och_q, och_d;
    logic [1:0]             q2_q, q2_d, q3_q, q3_d;
    logic [LAW:0]           ka2_q, ka2_d, kb2_q, kb2_d;
    logic [MPR-2:0]         ra3_q, ra3_d, rb3_q, rb3_d;
    logic signed [MPR-1:0]  sin_q, sin_d, cos_q, cos_d;

    logic [APR-1:0]         ph_full;
    logic signed [MPR-1:0]  pa, pb;
    logic                   chan_ok, apply, accept;
    logic                   unused_ph;

    // Bits below the table address are truncated by design
    assign unused_ph = ^ph_full[APR-LAW-3:0];

    // Next-state: slot scheduling, accumulate, config apply, pipeline advance
    always_comb begin
        acc_d      = acc_q;
        inc_d      = inc_q;
        off_d      = off_q;
        slot_d     = slot_q;
        pend_d     = pend_q;
        psel_d     = psel_q;
        pchan_d    = pchan_q;
        pdata_d    = pdata_q;
        vld_pipe_d = vld_pipe_q;
        ph1_d      = ph1_q;
        ch1_d      = ch1_q;
        ch2_d      = ch2_q;
        ch3_d      = ch3_q;
        och_d      = och_q;
        q2_d       = q2_q;
        q3_d       = q3_q;
        ka2_d      = ka2_q;
        kb2_d      = kb2_q;
        ra3_d      = ra3_q;
        rb3_d      = rb3_q;
        sin_d      = sin_q;
        cos_d      = cos_q;

        chan_ok = (int'(pchan_q) < NC);
        apply   = clken & pend_q & chan_ok & (pchan_q == slot_q);
        accept  = bus.cfg_valid & rdy_q;
        ph_full = acc_q[slot_q] + off_q[slot_q];
        pa      = $signed({1'b0, ra3_q});
        pb      = $signed({1'b0, rb3_q});

        if (clken) begin
            acc_d[slot_q] = acc_q[slot_q] + inc_q[slot_q];
            slot_d        = (int'(slot_q) == NC - 1) ? '0 : slot_q + CHW'(1);
            vld_pipe_d    = {vld_pipe_q[3:1], 1'b1};

            ph1_d = ph_full[APR-1 -: LAW+2];
            ch1_d = slot_q;

            q2_d  = ph1_q[LAW+1:LAW];
            ka2_d = {1'b0, ph1_q[LAW-1:0]};
            kb2_d = (LAW+1)'(N) - {1'b0, ph1_q[LAW-1:0]};
            ch2_d = ch1_q;

            ra3_d = rom[ka2_q];
            rb3_d = rom[kb2_q];
            q3_d  = q2_q;
            ch3_d = ch2_q;

            case (q3_q)
                2'd0:    begin sin_d =  pa; cos_d =  pb; end
                2'd1:    begin sin_d =  pb; cos_d = -pa; end
                2'd2:    begin sin_d = -pa; cos_d = -pb; end
                default: begin sin_d = -pb; cos_d =  pa; end
            endcase
            och_d = ch3_q;
        end

        // Update lands after this slot's own output/accumulate used old values
        if (apply) begin
            case (psel_q)
                2'd0:    inc_d[pchan_q] = pdata_q;
                2'd1:    off_d[pchan_q] = pdata_q;
                2'd2:    acc_d[pchan_q] = '0;
                default: ;
            endcase
        end

        if (accept) begin
            pend_d  = 1'b1;
            psel_d  = bus.cfg_sel;
            pchan_d = bus.cfg_chan;
            pdata_d = bus.cfg_data;
        end else if (pend_q & (apply | ~chan_ok)) begin
            pend_d = 1'b0;
        end
        rdy_d = ~pend_d;
    end

    // State registers; reset flushes everything, including in-flight samples
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            inc_q      <= '0;
            off_q      <= '0;
            slot_q     <= '0;
            pend_q     <= 1'b0;
            psel_q     <= '0;
            pchan_q    <= '0;
            pdata_q    <= '0;
            rdy_q      <= 1'b0;
            vld_pipe_q <= '0;
            ph1_q      <= '0;
            ch1_q      <= '0;
            ch2_q      <= '0;
            ch3_q      <= '0;
            och_q      <= '0;
            q2_q       <= '0;
            q3_q       <= '0;
            ka2_q      <= '0;
            kb2_q      <= '0;
            ra3_q      <= '0;
            rb3_q      <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            off_q      <= off_d;
            slot_q     <= slot_d;
            pend_q     <= pend_d;
            psel_q     <= psel_d;
            pchan_q    <= pchan_d;
            pdata_q    <= pdata_d;
            rdy_q      <= rdy_d;
            vld_pipe_q <= vld_pipe_d;
            ph1_q      <= ph1_d;
            ch1_q      <= ch1_d;
            ch2_q      <= ch2_d;
            ch3_q      <= ch3_d;
            och_q      <= och_d;
            q2_q       <= q2_d;
            q3_q       <= q3_d;
            ka2_q      <= ka2_d;
            kb2_q      <= kb2_d;
            ra3_q      <= ra3_d;
            rb3_q      <= rb3_d;
            sin_q      <= sin_d;
            cos_q      <= cos_d;
        end
    end

    assign bus.cfg_ready = rdy_q;
    assign bus.fsin_o    = sin_q;
    assign bus.fcos_o    = cos_q;
    assign bus.out_chan  = och_q;
    // A held sample is flagged only on clken cycles, so a clken-qualified
    // consumer sees each sample exactly once
    assign bus.out_valid = vld_pipe_q[4] & clken;
endmodule
